// File: rtl/timer_period_counter_if.sv
// Bus bundle between the timer control FSM and the period counter stage.
// The control side holds the master modport; the counter holds the slave modport.
interface timer_period_counter_if #(
    parameter int NUM_BITS = 16
);
    logic [NUM_BITS-1:0] cfg_start_i;
    logic [NUM_BITS-1:0] cfg_end_i;
    logic                cfg_sawtooth_i;
    logic                ctrl_rst_i;
    logic                ctrl_update_i;
    logic                ctrl_active_i;
    logic                evt_i;
    logic [NUM_BITS-1:0] counter_o;
    logic                dir_o;
    logic                end_o;
    logic                cnt_update_o;

    modport master (
        output cfg_start_i,
        output cfg_end_i,
        output cfg_sawtooth_i,
        output ctrl_rst_i,
        output ctrl_update_i,
        output ctrl_active_i,
        output evt_i,
        input  counter_o,
        input  dir_o,
        input  end_o,
        input  cnt_update_o
    );

    modport slave (
        input  cfg_start_i,
        input  cfg_end_i,
        input  cfg_sawtooth_i,
        input  ctrl_rst_i,
        input  ctrl_update_i,
        input  ctrl_active_i,
        input  evt_i,
        output counter_o,
        output dir_o,
        output end_o,
        output cnt_update_o
    );
endinterface

// File: rtl/timer_period_counter.sv
// PWM timer counter stage: sawtooth or up/down counting between shadowed
// start/end thresholds, with period-end and shadow-transfer pulses.
module timer_period_counter #(
    parameter int NUM_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    timer_period_counter_if.slave bus
);
    localparam logic [NUM_BITS-1:0] ONE = {{(NUM_BITS-1){1'b0}}, 1'b1};

    logic [NUM_BITS-1:0] cnt_q, cnt_d;
    logic [NUM_BITS-1:0] s_q, s_d;
    logic [NUM_BITS-1:0] e_q, e_d;
    logic                m_q, m_d;
    logic                dir_q, dir_d;
    logic                end_q, end_d;
    logic                upd_q, upd_d;
    logic                pend_q, pend_d;

    logic                load_end;
    logic [NUM_BITS-1:0] ns;
    logic [NUM_BITS-1:0] ne;
    logic                nm;
    logic                step;
    logic                wrap;
    logic                land_on_s;

    // Shadow values the next period will use if a period ends this cycle
    assign load_end  = pend_q | bus.ctrl_update_i;
    assign ns        = load_end ? bus.cfg_start_i    : s_q;
    assign ne        = load_end ? bus.cfg_end_i      : e_q;
    assign nm        = load_end ? bus.cfg_sawtooth_i : m_q;
    assign step      = bus.ctrl_active_i & bus.evt_i;
    assign land_on_s = m_q | (s_q == e_q) | (ns == ne);

    always_comb begin
        cnt_d  = cnt_q;
        s_d    = s_q;
        e_d    = e_q;
        m_d    = m_q;
        dir_d  = dir_q;
        pend_d = pend_q;
        end_d  = 1'b0;
        upd_d  = 1'b0;
        wrap   = 1'b0;
        if (bus.ctrl_rst_i) begin
            s_d    = bus.cfg_start_i;
            e_d    = bus.cfg_end_i;
            m_d    = bus.cfg_sawtooth_i;
            cnt_d  = bus.cfg_start_i;
            dir_d  = 1'b1;
            pend_d = 1'b0;
            upd_d  = 1'b1;
        end else if (bus.ctrl_update_i && !bus.ctrl_active_i) begin
            s_d    = bus.cfg_start_i;
            e_d    = bus.cfg_end_i;
            m_d    = bus.cfg_sawtooth_i;
            pend_d = 1'b0;
            upd_d  = 1'b1;
        end else begin
            if (bus.ctrl_update_i) pend_d = 1'b1;
            if (step) begin
                if (m_q) begin
                    if (cnt_q == e_q) wrap = 1'b1;
                    else              cnt_d = cnt_q + ONE;
                end else if (s_q == e_q) begin
                    wrap = 1'b1;
                end else if (dir_q) begin
                    if (cnt_q == e_q) begin
                        dir_d = 1'b0;
                        cnt_d = cnt_q - ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else if (cnt_q == s_q) begin
                    wrap = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
                // Triangle skips S on restart so S appears once per period
                if (wrap) begin
                    end_d = 1'b1;
                    dir_d = 1'b1;
                    cnt_d = land_on_s ? ns : ns + ONE;
                    if (load_end) begin
                        s_d    = ns;
                        e_d    = ne;
                        m_d    = nm;
                        upd_d  = 1'b1;
                        pend_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            s_q    <= '0;
            e_q    <= '0;
            m_q    <= 1'b1;
            dir_q  <= 1'b1;
            end_q  <= 1'b0;
            upd_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            s_q    <= s_d;
            e_q    <= e_d;
            m_q    <= m_d;
            dir_q  <= dir_d;
            end_q  <= end_d;
            upd_q  <= upd_d;
            pend_q <= pend_d;
        end
    end

    assign bus.counter_o    = cnt_q;
    assign bus.dir_o        = dir_q;
    assign bus.end_o        = end_q;
    assign bus.cnt_update_o = upd_q;
endmodule

// File: tb/tb_timer_period_counter.sv
// Bench for timer_period_counter: phase-position reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_timer_period_counter;
    localparam int W = 16;
    localparam int MASK = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic rst;

    timer_period_counter_if #(.NUM_BITS(W)) bus ();

    timer_period_counter #(.NUM_BITS(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference state: shadows, pending, and observable outputs
    int ms, me, mcnt;
    bit mm, mpend, mup, mend, mupd;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        ms = 0; me = 0; mm = 1; mpend = 0;
        mcnt = 0; mup = 1; mend = 0; mupd = 0;
    endtask

    task automatic model_load();
        ms = int'(bus.cfg_start_i);
        me = int'(bus.cfg_end_i);
        mm = bus.cfg_sawtooth_i;
    endtask

    // Triangle position: 0..span rising, span..2*span falling back to S
    task automatic model_step();
        bit done, old_saw, old_deg;
        int span, pos;
        mend = 0;
        mupd = 0;
        done = 0;
        if (bus.ctrl_rst_i) begin
            model_load();
            mcnt = ms; mup = 1; mpend = 0; mupd = 1;
        end else if (bus.ctrl_update_i && !bus.ctrl_active_i) begin
            model_load();
            mpend = 0; mupd = 1;
        end else begin
            if (bus.ctrl_update_i) mpend = 1;
            if (bus.ctrl_active_i && bus.evt_i) begin
                old_saw = mm;
                old_deg = (ms == me);
                span = me - ms;
                if (mm) begin
                    if (mcnt == me) done = 1;
                    else mcnt = (mcnt + 1) & MASK;
                end else if (span == 0) begin
                    done = 1;
                end else begin
                    pos = mup ? (mcnt - ms) : (2 * span - (mcnt - ms));
                    if (pos == 2 * span) begin
                        done = 1;
                    end else begin
                        pos++;
                        mup = (pos <= span);
                        mcnt = mup ? ms + pos : ms + 2 * span - pos;
                    end
                end
                if (done) begin
                    if (mpend || bus.ctrl_update_i) begin
                        model_load();
                        mupd = 1; mpend = 0;
                    end
                    mend = 1; mup = 1;
                    if (old_saw || old_deg || ms == me) mcnt = ms;
                    else mcnt = (ms + 1) & MASK;
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("model counter", 32'(bus.counter_o), mcnt);
            chk("model dir", 32'(bus.dir_o), 32'(mup));
            chk("model end", 32'(bus.end_o), 32'(mend));
            chk("model upd", 32'(bus.cnt_update_o), 32'(mupd));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input bit cr, input bit up, input bit ac,
                          input bit ev);
        bus.ctrl_rst_i    = cr;
        bus.ctrl_update_i = up;
        bus.ctrl_active_i = ac;
        bus.evt_i         = ev;
    endtask

    task automatic set_cfg(input int s, input int e, input bit saw);
        bus.cfg_start_i    = W'(s);
        bus.cfg_end_i      = W'(e);
        bus.cfg_sawtooth_i = saw;
    endtask

    int seq[8];
    int exp_ud[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    int n_end;

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        set_cfg(0, 0, 0);
        model_reset();
        @(negedge clk);
        chk("reset counter", 32'(bus.counter_o), 0);
        chk("reset dir", 32'(bus.dir_o), 1);
        chk("reset end", 32'(bus.end_o), 0);
        chk("reset upd", 32'(bus.cnt_update_o), 0);
        rst = 1'b0;
        chk_en = 1;

        // Sawtooth 2..5
        set_cfg(2, 5, 1);
        set_in(1, 0, 0, 0);
        tick();
        chk("saw start", 32'(bus.counter_o), 2);
        chk("saw upd pulse", 32'(bus.cnt_update_o), 1);
        set_in(0, 0, 1, 1);
        tick();
        chk("saw upd once", 32'(bus.cnt_update_o), 0);
        tick();
        tick();
        chk("saw at end", 32'(bus.counter_o), 5);
        tick();
        chk("saw wrap", 32'(bus.counter_o), 2);
        chk("saw end pulse", 32'(bus.end_o), 1);
        tick();
        chk("saw end cleared", 32'(bus.end_o), 0);

        // Up/down 0..3
        set_cfg(0, 3, 0);
        set_in(1, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        seq[0] = int'(bus.counter_o);
        for (int i = 1; i < 8; i++) begin
            tick();
            seq[i] = int'(bus.counter_o);
            if (i == 4) chk("ud dir down", 32'(bus.dir_o), 0);
            if (i == 7) chk("ud end", 32'(bus.end_o), 1);
        end
        for (int i = 0; i < 8; i++) chk("ud sequence", seq[i], exp_ud[i]);
        n_end = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n_end += int'(bus.end_o);
        end
        chk("ud ends per 12 evts", n_end, 2);

        // Deferred update
        set_cfg(0, 9, 1);
        set_in(1, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        repeat (3) tick();
        chk("defer at 3", 32'(bus.counter_o), 3);
        set_cfg(0, 4, 1);
        set_in(0, 1, 1, 1);
        tick();
        chk("defer no load", 32'(bus.cnt_update_o), 0);
        set_in(0, 0, 1, 1);
        repeat (5) tick();
        chk("defer at 9", 32'(bus.counter_o), 9);
        tick();
        chk("defer wrap cnt", 32'(bus.counter_o), 0);
        chk("defer wrap end", 32'(bus.end_o), 1);
        chk("defer wrap upd", 32'(bus.cnt_update_o), 1);
        repeat (4) tick();
        chk("defer new end", 32'(bus.counter_o), 4);
        tick();
        chk("defer short end", 32'(bus.end_o), 1);
        chk("defer short upd", 32'(bus.cnt_update_o), 0);

        // Immediate update while idle
        set_cfg(1, 6, 1);
        set_in(0, 1, 0, 1);
        tick();
        chk("idle upd", 32'(bus.cnt_update_o), 1);
        chk("idle hold", 32'(bus.counter_o), 0);
        set_in(0, 0, 0, 1);
        tick();
        chk("idle evt ignored", 32'(bus.counter_o), 0);
        chk("idle upd once", 32'(bus.cnt_update_o), 0);

        // Degenerate S=E=7
        set_cfg(7, 7, 0);
        set_in(1, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("deg counter", 32'(bus.counter_o), 7);
            chk("deg end", 32'(bus.end_o), 1);
        end

        // Wrap through zero with S > E
        set_cfg(16'hFFFE, 16'h0001, 1);
        set_in(1, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        tick();
        chk("wrap ffff", 32'(bus.counter_o), 32'hFFFF);
        tick();
        chk("wrap 0", 32'(bus.counter_o), 0);
        tick();
        chk("wrap 1", 32'(bus.counter_o), 1);
        tick();
        chk("wrap reload", 32'(bus.counter_o), 32'hFFFE);
        chk("wrap end", 32'(bus.end_o), 1);

        // ctrl_rst beats evt and update at counter == E
        set_cfg(0, 3, 1);
        set_in(1, 0, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        repeat (3) tick();
        set_cfg(5, 8, 1);
        set_in(1, 1, 1, 1);
        tick();
        chk("prio counter", 32'(bus.counter_o), 5);
        chk("prio end", 32'(bus.end_o), 0);
        chk("prio upd", 32'(bus.cnt_update_o), 1);

        // Async reset mid-count drops a pending update
        set_in(0, 0, 1, 1);
        repeat (2) tick();
        set_in(0, 1, 1, 1);
        tick();
        set_in(0, 0, 1, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst counter", 32'(bus.counter_o), 0);
        chk("rst dir", 32'(bus.dir_o), 1);
        chk("rst end", 32'(bus.end_o), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("rst pend lost upd", 32'(bus.cnt_update_o), 0);
        chk("rst pend lost cnt", 32'(bus.counter_o), 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
